// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared widths, queue entry and occupancy types for the register file write side
package regfile_writeback_pkg;
  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 6;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] adr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;
endpackage

// File: rtl/regfile_writeback_fwd_match.sv
// wb_fwd_match: youngest-match priority search over the pending writeback entries
module wb_fwd_match
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       tail,
  input  logic [RF_ADDR_W-1:0]   adr,
  output logic                   hit,
  output logic [RF_DATA_W-1:0]   data
);
  logic [PTR_W-1:0] idx;
  // walk oldest to youngest so the entry just behind the tail wins
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (valid[idx] && entries[idx].adr == adr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write queue feeding the register file write port, with forwarding lookup
// Optional: REGFILE_WB_ZERO_REG_EN makes register 0 hard-zero (never queued, never forwarded).
// DATA_W/ADDR_W must equal the package widths since entries use the shared wb_entry_t.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [ADDR_W-1:0]         inAdr,
  input  logic [DATA_W-1:0]         inData,
  input  logic                      wbStall,
  output logic [ADDR_W-1:0]         writeAdr,
  output logic [DATA_W-1:0]         writeData,
  output logic                      writeEnable,
  input  logic [ADDR_W-1:0]         fwdAdr,
  output logic                      fwdHit,
  output logic [DATA_W-1:0]         fwdData,
  output logic [$clog2(DEPTH):0]    pendCount
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W:0] head_q, head_d, tail_q, tail_d, cnt_d;
  occ_t state_q, state_d;
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic push, pop;
  logic [DEPTH-1:0] valid;
  logic match_hit;
  logic [DATA_W-1:0] match_data;
  // pointers and occupancy state; reset drops every pending entry
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= OCC_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      state_q <= state_d;
    end
  end
  // entry storage needs no reset: occupancy masks stale slots
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  // next state: pointer advance on push/pop, occupancy from the resulting count
  always_comb begin
    push = inValid && inReady
`ifdef REGFILE_WB_ZERO_REG_EN
      && inAdr != '0
`endif
      ;
    pop     = writeEnable;
    tail_d  = tail_q + (PTR_W+1)'(push);
    head_d  = head_q + (PTR_W+1)'(pop);
    cnt_d   = tail_d - head_d;
    state_d = cnt_d == '0 ? OCC_EMPTY : cnt_d[PTR_W] ? OCC_FULL : OCC_PARTIAL;
    mem_d   = mem_q;
    if (push) mem_d[tail_q[PTR_W-1:0]] = '{adr: inAdr, data: inData};
  end
  // handshake and write port; readiness depends only on registered state
  always_comb begin
    inReady     = state_q != OCC_FULL;
    writeEnable = state_q != OCC_EMPTY && !wbStall;
    writeAdr    = state_q == OCC_EMPTY ? '0 : mem_q[head_q[PTR_W-1:0]].adr;
    writeData   = state_q == OCC_EMPTY ? '0 : mem_q[head_q[PTR_W-1:0]].data;
  end
  // occupancy count and per-slot occupied mask relative to the head
  always_comb begin
    pendCount = tail_q - head_q;
    for (int i = 0; i < DEPTH; i++)
      valid[i] = {1'b0, PTR_W'(PTR_W'(i) - head_q[PTR_W-1:0])} < pendCount;
  end
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries (mem_q),
    .valid   (valid),
    .tail    (tail_q[PTR_W-1:0]),
    .adr     (fwdAdr),
    .hit     (match_hit),
    .data    (match_data)
  );
  // forwarding result, with register 0 never reported when hard-zero
  always_comb begin
`ifdef REGFILE_WB_ZERO_REG_EN
    fwdHit = match_hit && fwdAdr != '0;
`else
    fwdHit = match_hit;
`endif
    fwdData = fwdHit ? match_data : '0;
  end
endmodule
